// File: rtl/usb_ddr3_pkg.sv
// Shared definitions for the USB-to-DDR3 command sequencer: command opcodes,
// host status bytes, header geometry, FSM state encoding and small helpers.
package usb_ddr3_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam logic [7:0] STS_WR_OK = 8'h81;
    localparam logic [7:0] STS_ERR   = 8'hEE;

    // Header: opcode, addr[7:0], addr[15:8], addr[23:16], len[7:0], len[15:8]
    localparam int         HDR_LEN      = 6;
    localparam logic [2:0] HDR_LAST_IDX = 3'(HDR_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDAT,
        ST_WREQ,
        ST_RREQ,
        ST_RWAIT,
        ST_RSER,
        ST_DRAIN,
        ST_RESP
    } state_e;

    // States in which the BULK OUT stream is allowed to deliver bytes.
    function automatic logic accepts_input(input state_e s);
        return (s == ST_IDLE) || (s == ST_HDR) || (s == ST_WDAT) || (s == ST_DRAIN);
    endfunction

    // Little-endian byte lane selection within a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/axis_word_pack.sv
// 8->32 bit byte packer for the WRITE payload path.
// Ports:
//   clock, reset_n  - clock and synchronous active-low reset
//   clear           - discard any partially assembled word
//   in_valid/in_data- one payload byte accepted this cycle
//   word_last       - the next accepted byte completes a word (lane 3)
//   word            - assembled word, byte k in bits [8k+7:8k]
module axis_word_pack (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_last,
    output logic [31:0] word
);

    logic [1:0] byte_idx;

    assign word_last = (byte_idx == 2'd3);

    // NOTE: sequential state uses non-blocking assignments and the reset is
    // sampled inside the clocked block, so it is fully synchronous.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            byte_idx <= 2'd0;
            word     <= 32'd0;
        end else if (clear) begin
            // Only the lane pointer needs clearing; stale lanes are overwritten
            // before any word built from them can be issued.
            byte_idx <= 2'd0;
        end else if (in_valid) begin
            word[{byte_idx, 3'b000} +: 8] <= in_data;
            byte_idx                      <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/usb_ddr3_cmd_seq.sv
// Command sequencer between USB BULK OUT/IN byte streams and the DDR3 word port.
// Parses 6-byte command headers, performs N-word writes or reads, and returns
// read data or a one-byte status on BULK IN.
// Ports:
//   clock, reset_n                 - USB clock, synchronous active-low reset
//   s_t{valid,ready,last,data}     - BULK OUT byte stream (host -> device)
//   m_t{valid,ready,last,data}     - BULK IN byte stream (device -> host)
//   mem_wrreq/mem_rdreq, mem_ready - word request, held until accepted
//   mem_addr, mem_wdata            - request address and write word
//   mem_rvalid, mem_rdata          - read-data strobe and word
//   busy_o                         - sequencer not idle
module usb_ddr3_cmd_seq
    import usb_ddr3_pkg::*;
#(
    parameter int ADDR_WIDTH   = 24,
    parameter int MAX_LEN_LOG2 = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [7:0]            s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [7:0]            m_tdata,
    output logic                  mem_wrreq,
    output logic                  mem_rdreq,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  busy_o
);

    state_e                  state, state_n;
    logic                    err_q, err_n;
    logic [7:0]              opcode_q;
    logic [2:0]              hdr_idx;
    logic [23:0]             hdr_addr;
    logic [MAX_LEN_LOG2-1:0] len_q;
    logic [MAX_LEN_LOG2:0]   word_cnt;
    logic                    tlast_seen_q;
    logic                    rd_last_q;
    logic [31:0]             rword_q;
    logic [1:0]              ser_idx;
    logic                    pack_last;

    logic s_fire, m_fire, wr_acc, rd_acc, is_last;
    assign s_fire  = s_tvalid & s_tready;
    assign m_fire  = m_tvalid & m_tready;
    assign wr_acc  = mem_wrreq & mem_ready;
    assign rd_acc  = mem_rdreq & mem_ready;
    // Word counter holds the index of the word currently being transferred.
    assign is_last = (word_cnt == {1'b0, len_q});

    axis_word_pack u_pack (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     ((state != ST_WDAT) && (state != ST_WREQ)),
        .in_valid  (s_fire && (state == ST_WDAT)),
        .in_data   (s_tdata),
        .word_last (pack_last),
        .word      (mem_wdata)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n = state;
        err_n   = err_q;
        case (state)
            ST_IDLE: if (s_fire) begin
                err_n   = s_tlast;
                state_n = s_tlast ? ST_RESP : ST_HDR;
            end
            ST_HDR: if (s_fire) begin
                if (hdr_idx == HDR_LAST_IDX) begin
                    if (opcode_q == CMD_WRITE) begin
                        // A WRITE always carries at least one payload word.
                        err_n   = s_tlast;
                        state_n = s_tlast ? ST_RESP : ST_WDAT;
                    end else if (opcode_q == CMD_READ) begin
                        state_n = s_tlast ? ST_RREQ : ST_DRAIN;
                    end else begin
                        err_n   = 1'b1;
                        state_n = s_tlast ? ST_RESP : ST_DRAIN;
                    end
                end else if (s_tlast) begin
                    err_n   = 1'b1;
                    state_n = ST_RESP;
                end
            end
            ST_WDAT: if (s_fire) begin
                if (pack_last) begin
                    state_n = ST_WREQ;
                end else if (s_tlast) begin
                    err_n   = 1'b1;
                    state_n = ST_RESP;
                end
            end
            ST_WREQ: if (wr_acc) begin
                if (is_last) begin
                    state_n = tlast_seen_q ? ST_RESP : ST_DRAIN;
                end else if (tlast_seen_q) begin
                    // Frame ended on a word boundary but short of N words.
                    err_n   = 1'b1;
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_WDAT;
                end
            end
            // A zero-latency port may return data on the accept cycle itself.
            ST_RREQ:  if (rd_acc) state_n = mem_rvalid ? ST_RSER : ST_RWAIT;
            ST_RWAIT: if (mem_rvalid) state_n = ST_RSER;
            ST_RSER:  if (m_fire && (ser_idx == 2'd3)) state_n = rd_last_q ? ST_IDLE : ST_RREQ;
            ST_DRAIN: if (s_fire && s_tlast) begin
                state_n = ((opcode_q == CMD_READ) && !err_q) ? ST_RREQ : ST_RESP;
            end
            ST_RESP:  if (m_fire) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            err_q        <= 1'b0;
            s_tready     <= 1'b0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tdata      <= 8'd0;
            mem_wrreq    <= 1'b0;
            mem_rdreq    <= 1'b0;
            mem_addr     <= '0;
            busy_o       <= 1'b0;
            opcode_q     <= 8'd0;
            hdr_idx      <= 3'd0;
            hdr_addr     <= 24'd0;
            len_q        <= '0;
            word_cnt     <= '0;
            tlast_seen_q <= 1'b0;
            rd_last_q    <= 1'b0;
            rword_q      <= 32'd0;
            ser_idx      <= 2'd0;
        end else begin
            state <= state_n;
            err_q <= err_n;

            // Handshake outputs are registered copies of the next state.
            s_tready  <= accepts_input(state_n);
            busy_o    <= (state_n != ST_IDLE);
            mem_wrreq <= (state_n == ST_WREQ);
            mem_rdreq <= (state_n == ST_RREQ);
            m_tvalid  <= (state_n == ST_RSER) || (state_n == ST_RESP);

            if ((state == ST_IDLE) && s_fire) begin
                opcode_q     <= s_tdata;
                hdr_idx      <= 3'd1;
                tlast_seen_q <= 1'b0;
                word_cnt     <= '0;
            end

            if ((state == ST_HDR) && s_fire) begin
                hdr_idx <= hdr_idx + 3'd1;
                case (hdr_idx)
                    3'd1: hdr_addr[7:0]   <= s_tdata;
                    3'd2: hdr_addr[15:8]  <= s_tdata;
                    3'd3: hdr_addr[23:16] <= s_tdata;
                    3'd4: len_q[7:0]      <= s_tdata;
                    3'd5: begin
                        len_q[15:8] <= s_tdata;
                        mem_addr    <= hdr_addr[ADDR_WIDTH-1:0];
                    end
                    default: ;
                endcase
            end

            if ((state == ST_WDAT) && s_fire && s_tlast) tlast_seen_q <= 1'b1;

            if (wr_acc || rd_acc) begin
                mem_addr <= mem_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                word_cnt <= word_cnt + 1'b1;
            end
            if (rd_acc) rd_last_q <= is_last;

            if ((state_n == ST_RSER) && (state != ST_RSER)) begin
                rword_q <= mem_rdata;
                m_tdata <= mem_rdata[7:0];
                m_tlast <= 1'b0;
                ser_idx <= 2'd0;
            end else if ((state == ST_RSER) && m_fire && (ser_idx != 2'd3)) begin
                ser_idx <= ser_idx + 2'd1;
                m_tdata <= word_byte(rword_q, ser_idx + 2'd1);
                m_tlast <= rd_last_q && (ser_idx == 2'd2);
            end

            if ((state_n == ST_RESP) && (state != ST_RESP)) begin
                m_tdata <= err_n ? STS_ERR : STS_WR_OK;
                m_tlast <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_ddr3_cmd_seq.sv
// Directed bench for usb_ddr3_cmd_seq: write, read, error and drain frames,
// address wrap with memory/host stalls, and reset in the middle of a read.
module tb_usb_ddr3_cmd_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        s_tvalid, s_tready, s_tlast;
    logic [7:0]  s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [7:0]  m_tdata;
    logic        mem_wrreq, mem_rdreq, mem_ready;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy_o;

    always #5 clock = ~clock;

    usb_ddr3_cmd_seq dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .s_tdata    (s_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tdata    (m_tdata),
        .mem_wrreq  (mem_wrreq),
        .mem_rdreq  (mem_rdreq),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy_o     (busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Transaction logs, sampled on the falling edge.
    logic [7:0]  out_q[$];
    bit          out_last_q[$];
    logic [23:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [23:0] rd_addr_q[$];
    int          s_acc = 0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (m_tvalid && m_tready) begin
                out_q.push_back(m_tdata);
                out_last_q.push_back(m_tlast);
            end
            if (mem_wrreq && mem_ready) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (mem_rdreq && mem_ready) rd_addr_q.push_back(mem_addr);
            if (s_tvalid && s_tready) s_acc++;
        end
    end

    // Stall stability: a request or output byte not accepted must not change.
    bit          stab_en = 0;
    bit          p_mstall = 0, p_rstall = 0;
    logic [9:0]  p_m;
    logic [24:0] p_r;
    always @(negedge clock) begin
        if (stab_en && reset_n && p_mstall) check("m_hold", {m_tvalid, m_tlast, m_tdata}, p_m);
        if (stab_en && reset_n && p_rstall) check("rdreq_hold", {mem_rdreq, mem_addr}, p_r);
        p_mstall = reset_n && m_tvalid && !m_tready;
        p_rstall = reset_n && mem_rdreq && !mem_ready;
        p_m      = {m_tvalid, m_tlast, m_tdata};
        p_r      = {mem_rdreq, mem_addr};
    end

    // Memory model: one read response rd_lat cycles after acceptance.
    logic [31:0] mem_model [logic [23:0]];
    int          rd_lat = 3;
    int          rd_cnt = 0;
    bit          rd_pend = 0;
    bit          acc_seen = 0;
    logic [23:0] rd_pa, acc_a;
    always @(negedge clock) begin
        acc_seen = reset_n && mem_rdreq && mem_ready;
        acc_a    = mem_addr;
    end
    always @(posedge clock) begin
        #1;
        mem_rvalid = 1'b0;
        if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt <= 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_model.exists(rd_pa) ? mem_model[rd_pa] : 32'hDEADBEEF;
                rd_pend    = 0;
            end
        end
        if (acc_seen) begin
            rd_pend = 1;
            rd_cnt  = rd_lat;
            rd_pa   = acc_a;
        end
    end

    bit tog_en = 0;
    always @(posedge clock) begin
        #1;
        if (tog_en) m_tready = ~m_tready;
    end

    logic [7:0] fb [0:23];

    task automatic set_hdr(input logic [7:0] op, input logic [23:0] a, input logic [15:0] len);
        fb[0] = op;      fb[1] = a[7:0];   fb[2] = a[15:8];
        fb[3] = a[23:16]; fb[4] = len[7:0]; fb[5] = len[15:8];
    endtask

    // Called just after a rising edge; tlast accompanies byte n-1.
    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            bit ok;
            int w;
            ok = 0;
            w  = 0;
            s_tvalid = 1'b1;
            s_tdata  = fb[i];
            s_tlast  = (i == n - 1);
            do begin
                @(negedge clock);
                ok = s_tready;
                @(posedge clock);
                #1;
                w++;
            end while (!ok && w < 200);
            if (!ok) check("s_accept_timeout", 32'(ok), 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int n);
        int w;
        w = 0;
        while (out_q.size() < n && w < 400) begin
            @(posedge clock);
            #1;
            w++;
        end
        check({tag, "_out_count"}, out_q.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy_o && w < 400) begin
            @(posedge clock);
            #1;
            w++;
        end
        repeat (4) @(posedge clock);
        #1;
        check({tag, "_idle"}, busy_o, 0);
    endtask

    task automatic clear_logs();
        out_q.delete();
        out_last_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        s_acc = 0;
    endtask

    task automatic check_rst_outs(input string tag);
        check({tag, "_ctl"}, {s_tready, m_tvalid, m_tlast, mem_wrreq, mem_rdreq, busy_o}, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Compares the logged BULK IN bytes with up to two words, LSB first.
    task automatic check_read(input string tag, input logic [31:0] w0, input logic [31:0] w1, input int nw);
        logic [31:0] w;
        for (int i = 0; i < 4 * nw; i++) begin
            w = (i < 4) ? w0 : w1;
            if (i < out_q.size()) begin
                check({tag, "_byte"}, out_q[i], w[8 * (i % 4) +: 8]);
                check({tag, "_last"}, 32'(out_last_q[i]), 32'(i == 4 * nw - 1));
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        s_tdata   = 8'd0;
        m_tready  = 1'b1;
        mem_ready = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        mem_model[24'h000010] = 32'h44332211;
        mem_model[24'h000011] = 32'h88776655;
        mem_model[24'hFFFFFF] = 32'hA3A2A1A0;
        mem_model[24'h000000] = 32'hB3B2B1B0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_rst_outs("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // WRITE two words at 0x10
        clear_logs();
        set_hdr(8'h01, 24'h000010, 16'd1);
        for (int i = 0; i < 8; i++) fb[6 + i] = 8'(8'h11 * (i + 1));
        send_frame(14);
        wait_out("wr", 1);
        wait_idle("wr");
        check("wr_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("wr0_addr", wr_addr_q[0], 24'h000010);
            check("wr0_data", wr_data_q[0], 32'h44332211);
            check("wr1_addr", wr_addr_q[1], 24'h000011);
            check("wr1_data", wr_data_q[1], 32'h88776655);
        end
        if (out_q.size() > 0) begin
            check("wr_status", out_q[0], 8'h81);
            check("wr_status_last", 32'(out_last_q[0]), 1);
        end

        // READ two words at 0x10
        clear_logs();
        set_hdr(8'h02, 24'h000010, 16'd1);
        send_frame(6);
        wait_out("rd", 8);
        wait_idle("rd");
        check_read("rd", 32'h44332211, 32'h88776655, 2);
        check("rd_req_count", rd_addr_q.size(), 2);

        // Bad opcode, drained to tlast
        clear_logs();
        fb[0] = 8'h07;
        for (int i = 1; i < 11; i++) fb[i] = 8'(8'h30 + i);
        send_frame(11);
        wait_out("badop", 1);
        wait_idle("badop");
        check("badop_accepted", s_acc, 11);
        if (out_q.size() > 0) begin
            check("badop_status", out_q[0], 8'hEE);
            check("badop_last", 32'(out_last_q[0]), 1);
        end
        check("badop_mem_reqs", wr_addr_q.size() + rd_addr_q.size(), 0);

        // Short WRITE payload: first word written, partial second word dropped
        clear_logs();
        set_hdr(8'h01, 24'h000020, 16'd1);
        for (int i = 0; i < 6; i++) fb[6 + i] = 8'(8'hA0 + i);
        send_frame(12);
        wait_out("short", 1);
        wait_idle("short");
        check("short_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) begin
            check("short_wr_addr", wr_addr_q[0], 24'h000020);
            check("short_wr_data", wr_data_q[0], 32'hA3A2A1A0);
        end
        if (out_q.size() > 0) check("short_status", out_q[0], 8'hEE);
        check("short_out_total", out_q.size(), 1);

        // READ across the address wrap with memory and host stalls
        clear_logs();
        stab_en   = 1;
        mem_ready = 1'b0;
        set_hdr(8'h02, 24'hFFFFFF, 16'd1);
        send_frame(6);
        repeat (5) @(posedge clock);
        #1;
        check("stall_rdreq_held", mem_rdreq, 1);
        check("stall_no_accept", rd_addr_q.size(), 0);
        mem_ready = 1'b1;
        tog_en    = 1;
        wait_out("wrap", 8);
        wait_idle("wrap");
        tog_en   = 0;
        stab_en  = 0;
        m_tready = 1'b1;
        check_read("wrap", 32'hA3A2A1A0, 32'hB3B2B1B0, 2);
        check("wrap_req_count", rd_addr_q.size(), 2);
        if (rd_addr_q.size() == 2) begin
            check("wrap_addr0", rd_addr_q[0], 24'hFFFFFF);
            check("wrap_addr1", rd_addr_q[1], 24'h000000);
        end

        // Reset while serializing byte 2 of a read word
        clear_logs();
        set_hdr(8'h02, 24'h000010, 16'd0);
        send_frame(6);
        wait_out("rst_mid", 2);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_rst_outs("rst_mid");
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // READ after reset, with two trailing bytes to drain first
        clear_logs();
        set_hdr(8'h02, 24'h000011, 16'd0);
        fb[6] = 8'h5A;
        fb[7] = 8'h5B;
        send_frame(8);
        wait_out("post_rst", 4);
        wait_idle("post_rst");
        check_read("post_rst", 32'h88776655, 32'h0, 1);
        check("post_rst_req_count", rd_addr_q.size(), 1);
        if (rd_addr_q.size() > 0) check("post_rst_addr", rd_addr_q[0], 24'h000011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_ddr3_cmd_seq.md
# usb_ddr3_cmd_seq

Command sequencer between the USB BULK OUT/IN byte streams and the DDR3 core's 32-bit word memory port. It parses host command frames arriving on the BULK OUT AXI-Stream and issues word-granular write or read requests to DDR3. Read data, or a one-byte status, goes back to the host on the BULK IN stream. It sits in the USB clock domain, between `usb_ulpi_core` and the DDR3 controller's user port.

## Interface
- `ADDR_WIDTH`, 24: DDR3 word-address width (≤24); header address bits above this are ignored.
- `MAX_LEN_LOG2`, 16: width of the frame length field; fixed by the header format.

- `clock` in 1: USB bus clock (60 MHz); all logic on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `s_tvalid`/`s_tready`/`s_tlast` in/out/in 1: BULK OUT byte stream handshake.
- `s_tdata` in 8: BULK OUT byte.
- `m_tvalid`/`m_tready`/`m_tlast` out/in/out 1: BULK IN byte stream handshake.
- `m_tdata` out 8: BULK IN byte.
- `mem_wrreq`/`mem_rdreq` out 1: word write/read request, held until accepted.
- `mem_ready` in 1: request accepted on a cycle where `mem_ready` and a request are both high.
- `mem_addr` out ADDR_WIDTH: word address.
- `mem_wdata` out 32: write word, little-endian byte packing.
- `mem_rvalid` in 1: one-cycle read-data strobe.
- `mem_rdata` in 32: read word.
- `busy_o` out 1: high whenever state ≠ ST_IDLE.

## Operation
- Frame header is 6 bytes: opcode, addr[7:0], addr[15:8], addr[23:16], len[7:0], len[15:8]. Word count N = len+1 (1..65536).
- Opcode 0x01 (WRITE): header followed by 4N payload bytes. Byte k of each word maps to `mem_wdata[8k+7:8k]`. One write is issued per completed word; address post-increments mod 2^ADDR_WIDTH. On completion, emit status byte 0x81 with `m_tlast`=1.
- Opcode 0x02 (READ): header only; tlast is expected on byte 5. N reads are issued with exactly one outstanding. Each returned word is serialized to `m_tdata` LSB first. `m_tlast` is set on the final byte of word N only.
- Error response: emit a single byte 0xEE with `m_tlast`=1, after draining to `s_tlast`. Cases:
  - Opcode not 0x01/0x02.
  - `s_tlast` arrives inside the header.
  - WRITE payload `s_tlast` arrives before byte 4N. Words already written stay written; a partial word is discarded and never written.
- Extra bytes after byte 4N of a WRITE, or after the header of a READ, are drained to `s_tlast` before execution or status. This is not an error.
- States and transitions:
  - ST_IDLE: on byte accepted → ST_HDR.
  - ST_HDR: after 6 bytes → ST_WDAT (write), ST_RREQ (read), or ST_DRAIN (error).
  - ST_WDAT: 4th byte of a word → ST_WREQ.
  - ST_WREQ: on accept → ST_WDAT, or ST_DRAIN/ST_RESP when done.
  - ST_RREQ → ST_RWAIT on accept.
  - ST_RWAIT → ST_RSER on `mem_rvalid`.
  - ST_RSER: after 4 bytes → ST_RREQ, or ST_IDLE after word N.
  - ST_DRAIN: on `s_tlast` → ST_RESP, or ST_RREQ for a read whose header lacked tlast.
  - ST_RESP: on byte accepted → ST_IDLE.
- Counters:
  - Byte-in-word counter: 2 bits.
  - Word counter: 17 bits, compared against N.
  - Header index: 3 bits.
- Simultaneous events:
  - `mem_rvalid` arriving while in ST_RREQ (zero-latency port) is captured, not dropped.
  - `s_tlast` on byte 4N of a WRITE is normal completion.

## Timing
- Reset values: `s_tready`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `mem_wrreq`=0, `mem_rdreq`=0, `mem_addr`=0, `mem_wdata`=0, `busy_o`=0, state ST_IDLE.
- `s_tready` is registered; high only in ST_IDLE, ST_HDR, ST_WDAT and ST_DRAIN.
- `mem_wrreq` rises the cycle after the 4th byte of a word is accepted. It and its address/data are held stable until accepted.
- `mem_rdreq` is held stable until accepted.
- First `m_tvalid` of a read word is the cycle after `mem_rvalid`. One byte per cycle when `m_tready`=1.
- `m_tdata`/`m_tlast` are held while `m_tvalid`=1 and `m_tready`=0.
- Status byte is valid 1 cycle after the final write accept or after draining completes.
- Reset mid-operation: all outputs return to reset values the next cycle. In-flight requests are abandoned; `mem_rvalid` after reset is ignored.

## Structure
- Shared package `usb_ddr3_pkg` holds:
  - Opcodes CMD_WRITE=8'h01, CMD_READ=8'h02.
  - Status bytes STS_WR_OK=8'h81, STS_ERR=8'hEE.
  - Header length 6.
  - State encoding.
- One natural sub-module: `axis_word_pack`, the 8→32 byte packer with byte counter and partial-word discard. Read serialization stays inline.

## Test plan
- WRITE addr 0x000010, len 1, payload 11 22 33 44 55 66 77 88 → writes 0x44332211@0x10 and 0x88776655@0x11; status 0x81 with tlast.
- READ addr 0x000010, len 1, memory model with 3-cycle latency → output 11 22 33 44 55 66 77 88; tlast on 0x88 only.
- Opcode 0x07 followed by 10 bytes, tlast on the last byte → all bytes accepted; single 0xEE; no memory request.
- WRITE len 1 with tlast on payload byte 6 → one write (word 0); 0xEE; no second request.
- READ addr 0xFFFFFF, len 1, ADDR_WIDTH=24, `mem_ready` low for 5 cycles and `m_tready` toggling every cycle → addresses 0xFFFFFF then 0x000000; requests and bytes stable under stall.
- Assert `reset_n`=0 during ST_RSER byte 2 → next cycle all outputs at reset values; a following READ frame executes correctly.
